neopix_frame_scheduler: RTL and testbench
=========================================

// Module: neopix_frame_scheduler
// PURPOSE
//  Sits between the SPI byte receiver and the ws2812 driver. Owns two GRB frame banks.
//  Fills the back bank from SPI bytes and swaps banks only at a driver reset gap.
//  Serves driver data requests from the front bank.
//  Holds the driver in reset until the first complete frame arrives.
// PARAMETERS
//  NUM_LEDS      8    LEDs in chain; each bank holds NUM_LEDS*3 bytes, G,R,B order
//  BYTES_W       derived, $clog2(NUM_LEDS*3)+1; width of byte counts
//  ADDR_W        derived, $clog2(NUM_LEDS); width of LED address
// PORTS
//  clk             in   1        system clock (50 MHz)
//  reset           in   1        synchronous, active-high
//  wr_start        in   1        1-cycle pulse: SPI select asserted (frame begin)
//  wr_valid        in   1        1-cycle pulse: wr_data holds a received byte
//  wr_data         in   8        received byte
//  wr_end          in   1        1-cycle pulse: SPI select released (frame end)
//  wr_overflow     out  1        1-cycle pulse: byte dropped, frame already full
//  drv_reset       out  1        reset to ws2812 driver
//  drv_reset_state in   1        driver is in its latch/reset gap
//  drv_data_req    in   1        driver requests colour for drv_addr
//  drv_addr        in   ADDR_W   LED index requested
//  red/green/blue  out  8 each   colour to driver, registered
//  frames_shown    out  8        bank-swap counter, wraps 255->0
//  busy            out  1        writer FSM not in W_IDLE
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, except drv_reset=1
//   - front bank index 0, front and back counts 0, pending=0, have_frame=0, FSM W_IDLE
//   - bank RAM contents are not cleared; count gating hides stale data
//  Writer FSM: W_IDLE, W_FILL, W_PEND
//   - W_IDLE --wr_start--> W_FILL: index<=0, back count<=0
//   - W_FILL on wr_valid:
//       index<NUM_LEDS*3: back[index]<=wr_data, index++, back count<=index+1
//       otherwise: byte dropped, wr_overflow pulses next cycle
//   - W_FILL --wr_end--> W_PEND: pending<=1
//   - W_FILL --wr_start--> restart: index<=0, count<=0; partial frame discarded
//   - W_PEND --wr_start--> W_FILL: newest frame wins, pending<=0
//   - wr_start and wr_valid in same cycle: start wins, byte ignored
//   - wr_start and wr_end in same cycle: start wins
//   - wr_valid/wr_end in W_IDLE: ignored; wr_valid/wr_end in W_PEND: ignored
//  Bank swap:
//   - detected on the rising edge of drv_reset_state (registered previous value 0, current 1)
//   - condition: pending==1 in the same cycle as the edge
//   - front index toggles; front count <= back count
//   - frames_shown++, pending<=0, have_frame<=1, FSM -> W_IDLE
//   - swap and a new wr_start in the same cycle: swap wins, FSM enters W_FILL on the new back bank
//   - pending set on the edge cycle is not seen; swap waits for the next edge
//   - no swap mid-frame; the front bank is never written
//  Driver read:
//   - on drv_data_req, green/red/blue <= front[a*3], front[a*3+1], front[a*3+2]
//     next cycle (latency 1); a=drv_addr
//   - a*3+2 >= front count: all three outputs 0 (partial frame tail is black)
//   - outputs hold between requests
//   - index arithmetic in BYTES_W+2 bits, no truncation
//  drv_reset = reset | ~have_frame, registered
//  Frame sizes:
//   - zero-byte frame (start then end): valid, all LEDs black
//   - frame with a count that is not a multiple of 3: the trailing LED is black
//  Reset mid-operation: reset wins over any other event; the next frame starts clean
// TESTING
//  1. Reset, then 24 bytes 0x01..0x18, end, reset-state edge.
//     -> drv_reset falls, frames_shown=1, LED0 G/R/B=01/02/03, LED7=16/17/18.
//  2. 5 bytes, then read LED1 and LED2.
//     -> LED1 all 0 (only 2 of 3 bytes), LED2 all 0.
//  3. 26 bytes sent.
//     -> 2 wr_overflow pulses, LED7 = bytes 22..24.
//  4. Frame A complete, pending; frame B starts and ends before the reset edge.
//     -> display shows B after one swap; frames_shown +1 only.
//  5. wr_end in the same cycle as the reset-state edge.
//     -> no swap that gap; swap on the next edge.
//  6. reset asserted mid-W_FILL.
//     -> busy=0, drv_reset=1, colours 0; the next full frame displays correctly.

Source files
------------

// File: rtl/neopix_frame_scheduler_if.sv
// Bundle of the SPI-writer and ws2812-driver facing signals of the frame scheduler.
// Protocol has no ready: wr_start/wr_valid/wr_end are single-cycle pulses always accepted, and a drv_data_req returns colour one cycle later.
interface neopix_frame_scheduler_if #(
  parameter int NUM_LEDS = 8
);
  localparam int ADDR_W = $clog2(NUM_LEDS);

  logic              wr_start;
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_end;
  logic              wr_overflow;
  logic              drv_reset;
  logic              drv_reset_state;
  logic              drv_data_req;
  logic [ADDR_W-1:0] drv_addr;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic [7:0]        frames_shown;
  logic              busy;
  logic [1:0]        wr_state;

  modport master (
    output wr_start, wr_valid, wr_data, wr_end, drv_reset_state, drv_data_req, drv_addr,
    input  wr_overflow, drv_reset, red, green, blue, frames_shown, busy, wr_state
  );

  modport slave (
    input  wr_start, wr_valid, wr_data, wr_end, drv_reset_state, drv_data_req, drv_addr,
    output wr_overflow, drv_reset, red, green, blue, frames_shown, busy, wr_state
  );
endinterface

// File: rtl/neopix_frame_scheduler.sv
// Double-buffered GRB frame store: SPI bytes fill the back bank, banks swap only at a
// driver reset gap, and the driver reads colours from the front bank.
module neopix_frame_scheduler #(
  parameter int NUM_LEDS = 8
) (
  input logic                    clk,
  input logic                    reset,
  neopix_frame_scheduler_if.slave bus
);
  localparam int BYTES   = NUM_LEDS * 3;
  localparam int BYTES_W = $clog2(BYTES) + 1;
  localparam int ADDR_W  = $clog2(NUM_LEDS);
  localparam int IDX_W   = $clog2(BYTES);
  localparam int RD_W    = BYTES_W + 2;
  localparam logic [BYTES_W-1:0] BYTES_MAX = BYTES_W'(BYTES);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_PEND = 2'd2
  } w_state_t;

  w_state_t           state;
  logic [7:0]         bank [2][BYTES];
  logic               front;
  logic [BYTES_W-1:0] front_cnt;
  logic [BYTES_W-1:0] back_cnt;
  logic [BYTES_W-1:0] index;
  logic               pending;
  logic               have_frame;
  logic               rs_prev;

  logic               swap;
  logic               wr_take;
  logic               rd_in_range;
  logic [RD_W-1:0]    base;
  logic [IDX_W-1:0]   idx0, idx1, idx2;

  // pending is the registered value, so a frame ending on the edge cycle waits for the next gap
  assign swap    = bus.drv_reset_state & ~rs_prev & pending;
  assign wr_take = !swap && (state == W_FILL) && !bus.wr_start && bus.wr_valid
                   && (index < BYTES_MAX);

  assign base        = RD_W'(bus.drv_addr) * RD_W'(3);
  assign rd_in_range = (base + RD_W'(2)) < RD_W'(front_cnt);
  assign idx0        = base[IDX_W-1:0];
  assign idx1        = IDX_W'(base + RD_W'(1));
  assign idx2        = IDX_W'(base + RD_W'(2));

  assign bus.busy     = (state != W_IDLE);
  assign bus.wr_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= W_IDLE;
      front            <= 1'b0;
      front_cnt        <= '0;
      back_cnt         <= '0;
      index            <= '0;
      pending          <= 1'b0;
      have_frame       <= 1'b0;
      rs_prev          <= 1'b0;
      bus.frames_shown <= 8'd0;
      bus.wr_overflow  <= 1'b0;
      bus.drv_reset    <= 1'b1;
    end else begin
      rs_prev         <= bus.drv_reset_state;
      bus.wr_overflow <= 1'b0;
      bus.drv_reset   <= ~have_frame;
      if (swap) begin
        front            <= ~front;
        front_cnt        <= back_cnt;
        bus.frames_shown <= bus.frames_shown + 8'd1;
        pending          <= 1'b0;
        have_frame       <= 1'b1;
        if (bus.wr_start) begin
          state    <= W_FILL;
          index    <= '0;
          back_cnt <= '0;
        end else begin
          state <= W_IDLE;
        end
      end else begin
        case (state)
          W_IDLE: begin
            if (bus.wr_start) begin
              state    <= W_FILL;
              index    <= '0;
              back_cnt <= '0;
            end
          end
          W_FILL: begin
            if (bus.wr_start) begin
              index    <= '0;
              back_cnt <= '0;
            end else begin
              if (bus.wr_valid) begin
                if (index < BYTES_MAX) begin
                  index    <= index + 1'b1;
                  back_cnt <= index + 1'b1;
                end else begin
                  bus.wr_overflow <= 1'b1;
                end
              end
              if (bus.wr_end) begin
                state   <= W_PEND;
                pending <= 1'b1;
              end
            end
          end
          W_PEND: begin
            if (bus.wr_start) begin
              state    <= W_FILL;
              pending  <= 1'b0;
              index    <= '0;
              back_cnt <= '0;
            end
          end
          default: state <= W_IDLE;
        endcase
      end
    end
  end

  // Bank RAM is never cleared; the byte counts hide stale contents
  always_ff @(posedge clk) begin
    if (wr_take) begin
      bank[~front][index[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.green <= 8'd0;
      bus.red   <= 8'd0;
      bus.blue  <= 8'd0;
    end else if (bus.drv_data_req) begin
      if (rd_in_range) begin
        bus.green <= bank[front][idx0];
        bus.red   <= bank[front][idx1];
        bus.blue  <= bank[front][idx2];
      end else begin
        bus.green <= 8'd0;
        bus.red   <= 8'd0;
        bus.blue  <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_neopix_frame_scheduler.sv
// Directed bench for neopix_frame_scheduler: table-driven LED reads plus hand-written
// sequences for overflow, frame replacement, edge timing and mid-frame reset.
module tb_neopix_frame_scheduler;
  localparam int NUM_LEDS = 8;
  localparam int ADDR_W   = $clog2(NUM_LEDS);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       exp_grb;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   ovf_cnt;
  int   n_vecs;
  vec_t vecs [16];
  logic [23:0] exp_q [$];

  neopix_frame_scheduler_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  neopix_frame_scheduler #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_start();
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
  endtask

  task automatic send_end();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    tick();
    bus.wr_valid = 1'b0;
    if (bus.wr_overflow) ovf_cnt++;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) send_byte(8'(first + k));
  endtask

  task automatic gap();
    bus.drv_reset_state = 1'b1;
    tick();
    bus.drv_reset_state = 1'b0;
    tick();
  endtask

  task automatic read_led(input logic [ADDR_W-1:0] a, input logic [23:0] exp, input string name);
    logic [23:0] want;
    bus.drv_data_req = 1'b1;
    bus.drv_addr     = a;
    tick();
    bus.drv_data_req = 1'b0;
    exp_q.push_back(exp);
    want = exp_q.pop_front();
    check(name, {8'd0, bus.green, bus.red, bus.blue}, {8'd0, want});
  endtask

  task automatic add_vec(input logic [ADDR_W-1:0] a, input logic [23:0] e);
    vecs[n_vecs].addr    = a;
    vecs[n_vecs].exp_grb = e;
    n_vecs++;
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < n_vecs; i++) read_led(vecs[i].addr, vecs[i].exp_grb, name);
    n_vecs = 0;
  endtask

  initial begin
    checks = 0; errors = 0; ovf_cnt = 0; n_vecs = 0;
    reset = 1'b1;
    bus.wr_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = 8'd0; bus.wr_end = 1'b0;
    bus.drv_reset_state = 1'b0; bus.drv_data_req = 1'b0; bus.drv_addr = '0;
    repeat (3) tick();

    check("rst_drv_reset", 32'(bus.drv_reset), 32'd1);
    check("rst_frames", 32'(bus.frames_shown), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rgb", {8'd0, bus.green, bus.red, bus.blue}, 32'd0);
    check("rst_ovf", 32'(bus.wr_overflow), 32'd0);
    reset = 1'b0;
    tick();
    check("held_drv_reset", 32'(bus.drv_reset), 32'd1);

    // 1: full frame 01..18
    send_start();
    check("fill_busy", 32'(bus.busy), 32'd1);
    send_bytes(8'h01, 24);
    send_end();
    check("pend_state", 32'(bus.wr_state), 32'd2);
    gap();
    check("t1_drv_reset", 32'(bus.drv_reset), 32'd0);
    check("t1_frames", 32'(bus.frames_shown), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);
    add_vec(0, 24'h010203); add_vec(1, 24'h040506); add_vec(2, 24'h070809);
    add_vec(3, 24'h0a0b0c); add_vec(4, 24'h0d0e0f); add_vec(5, 24'h101112);
    add_vec(6, 24'h131415); add_vec(7, 24'h161718);
    run_vecs("t1_led");

    // 2: five-byte frame, partial LED1 and stale tail are black
    send_start();
    send_bytes(8'ha1, 5);
    send_end();
    gap();
    check("t2_frames", 32'(bus.frames_shown), 32'd2);
    add_vec(0, 24'ha1a2a3); add_vec(1, 24'h000000); add_vec(2, 24'h000000);
    add_vec(7, 24'h000000); add_vec(0, 24'ha1a2a3);
    run_vecs("t2_led");
    repeat (2) tick();
    check("t2_hold", {8'd0, bus.green, bus.red, bus.blue}, 32'h00a1a2a3);

    // 3: 26 bytes, last two dropped
    ovf_cnt = 0;
    send_start();
    send_bytes(8'h31, 26);
    send_end();
    check("t3_ovf_cnt", 32'(ovf_cnt), 32'd2);
    gap();
    check("t3_frames", 32'(bus.frames_shown), 32'd3);
    add_vec(7, 24'h464748); add_vec(0, 24'h313233);
    run_vecs("t3_led");

    // 4: frame A pending, frame B replaces it before the gap
    send_start();
    send_bytes(8'h61, 24);
    send_end();
    send_start();
    send_bytes(8'h81, 24);
    send_end();
    gap();
    check("t4_frames", 32'(bus.frames_shown), 32'd4);
    add_vec(0, 24'h818283); add_vec(7, 24'h969798);
    run_vecs("t4_led");
    gap();
    check("t4_no_extra_swap", 32'(bus.frames_shown), 32'd4);

    // 5: wr_end on the edge cycle defers the swap to the next gap
    send_start();
    send_bytes(8'hc1, 24);
    bus.wr_end = 1'b1;
    bus.drv_reset_state = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    bus.drv_reset_state = 1'b0;
    tick();
    check("t5_no_swap", 32'(bus.frames_shown), 32'd4);
    read_led(0, 24'h818283, "t5_old_led");
    gap();
    check("t5_swap", 32'(bus.frames_shown), 32'd5);
    read_led(0, 24'hc1c2c3, "t5_new_led");

    // 6: reset mid-fill, then restart and start+valid collision
    send_start();
    send_bytes(8'h11, 3);
    check("t6_busy_fill", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_drv_reset", 32'(bus.drv_reset), 32'd1);
    check("t6_rgb", {8'd0, bus.green, bus.red, bus.blue}, 32'd0);
    check("t6_frames", 32'(bus.frames_shown), 32'd0);
    tick();
    send_start();
    send_byte(8'h99);
    bus.wr_start = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'hee;
    tick();
    bus.wr_start = 1'b0; bus.wr_valid = 1'b0;
    send_bytes(8'h21, 24);
    send_end();
    gap();
    check("t6_drv_reset_low", 32'(bus.drv_reset), 32'd0);
    check("t6_frames_after", 32'(bus.frames_shown), 32'd1);
    add_vec(0, 24'h212223); add_vec(7, 24'h363738);
    run_vecs("t6_led");

    // zero-byte frame shows all black
    send_start();
    send_end();
    gap();
    check("zero_frames", 32'(bus.frames_shown), 32'd2);
    add_vec(0, 24'h000000); add_vec(7, 24'h000000);
    run_vecs("zero_led");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
